// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: FSM encoding, IF/ID payload and PC helpers.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus; single outstanding request.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output req, addr, input rdata, rvalid);
    modport slave  (input req, addr, output rdata, rvalid);
endinterface

// File: rtl/if_id_reg.sv
// Pipeline register for {instr, pc, valid}; clear inserts a bubble, load captures, else hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clr_i,
    input  logic [31:0] clr_pc_i,
    input  ifid_t       d_i,
    output ifid_t       q_o
);

    ifid_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '{instr: NOP_INSTR, pc: clr_pc_i, valid: 1'b0};
        end else if (load_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) q_q <= '{instr: NOP_INSTR, pc: RESET_PC, valid: 1'b0};
        else      q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and a single-outstanding imem handshake, feeds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_if,
    input  logic                 flush,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [31:0]          if_instr,
    output logic [31:0]          if_pc,
    output logic                 if_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_buf_q, hold_buf_d;
    logic         discard_q, discard_d;

    logic [31:0]  redir, pc_inc;
    logic         ifid_ld, ifid_clr;
    ifid_t        ifid_d, ifid_q;

    assign redir  = align_pc(redirect_pc);
    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_buf_d = hold_buf_q;
        discard_d  = discard_q;
        imem.req   = 1'b0;
        imem.addr  = pc_q;
        ifid_ld    = 1'b0;
        ifid_d     = '{instr: imem.rdata, pc: pc_q, valid: 1'b1};
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (flush) pc_d = redir;
            end
            ST_REQ: begin
                // A flushed request still goes out; its response is marked for discard.
                if (flush) begin
                    imem.req  = 1'b1;
                    pc_d      = redir;
                    discard_d = 1'b1;
                    state_d   = ST_WAIT;
                end else if (!stall_if) begin
                    imem.req = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    pc_d = redir;
                    if (imem.rvalid) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem.rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else if (!stall_if) begin
                        // Consume and re-issue in one cycle for back-to-back fetch.
                        ifid_ld   = 1'b1;
                        pc_d      = pc_inc;
                        imem.req  = 1'b1;
                        imem.addr = pc_inc;
                    end else begin
                        hold_buf_d = imem.rdata;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_d    = redir;
                    state_d = ST_REQ;
                end else if (!stall_if) begin
                    ifid_ld = 1'b1;
                    ifid_d  = '{instr: hold_buf_q, pc: pc_q, valid: 1'b1};
                    pc_d    = pc_inc;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // When decode advances with no new word, IF/ID drains to a bubble so nothing repeats.
    assign ifid_clr = flush | (~ifid_ld & ~stall_if);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            hold_buf_q <= 32'd0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_buf_q <= hold_buf_d;
            discard_q  <= discard_d;
        end
    end

    if_id_reg #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ifid_ld),
        .clr_i    (ifid_clr),
        .clr_pc_i (flush ? redir : pc_q),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign if_instr = ifid_q.instr;
    assign if_pc    = ifid_q.pc;
    assign if_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-configurable imem model plus an in-order PC scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] if_instr, if_pc;
    logic        if_valid;

    fetch_stage_if imem_bus();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_if    (stall_if),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus.master),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_valid    (if_valid)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          consumed = 0;
    int          lat = 1;
    bit          mem_err = 1'b0;
    logic [31:0] exp_q[$];

    // Memory: a request seen in cycle t is answered during cycle t+lat with ~addr.
    initial begin
        logic        req_s, rst_s;
        logic [31:0] addr_s, paddr;
        bit          pend;
        int          cnt;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = 32'd0;
        pend = 1'b0; cnt = 0; paddr = 32'd0;
        forever begin
            @(negedge clk);
            req_s = imem_bus.req; addr_s = imem_bus.addr; rst_s = rst;
            @(posedge clk);
            #1;
            imem_bus.rvalid = 1'b0;
            if (!rst_s) begin
                pend = 1'b0;
            end else begin
                if (req_s) begin
                    if (pend) mem_err = 1'b1;
                    pend = 1'b1; cnt = lat - 1; paddr = addr_s;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        imem_bus.rvalid = 1'b1;
                        imem_bus.rdata  = ~paddr;
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // One cycle; decode consumes IF/ID at the negedge when it is valid and not stalled/flushed.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (rst && if_valid && !stall_if && !flush) begin
            checks++; consumed++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_extra: got pc=%h instr=%h, nothing expected", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                if (if_pc !== e || if_instr !== ~e)
                    $display("FAIL sb_order: got pc=%h instr=%h, want pc=%h instr=%h", if_pc, if_instr, e, ~e);
                else passed++;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic do_reset();
        rst = 1'b0; stall_if = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b1;
        consumed = 0;
        exp_q.delete();
    endtask

    task automatic finish_test(input string name, input int exp_cnt);
        rst = 1'b0;
        checks++;
        if (consumed !== exp_cnt || exp_q.size() != 0)
            $display("FAIL %s_count: consumed %0d (left %0d), want %0d", name, consumed, exp_q.size(), exp_cnt);
        else passed++;
        checks++;
        if (mem_err) $display("FAIL %s_outstanding: second request while one unresolved", name);
        else passed++;
        mem_err = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h0 || imem_bus.req !== 1'b0)
            $display("FAIL reset: valid=%b instr=%h pc=%h req=%b, want 0 00000013 0 0", if_valid, if_instr, if_pc, imem_bus.req);
        else passed++;
    endtask

    task automatic test_stream();
        lat = 1; do_reset(); push_seq(32'h0, 7);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'(4 * i))
                $display("FAIL stream_addr%0d: req=%b addr=%h, want 1 %h", i, imem_bus.req, imem_bus.addr, 32'(4 * i));
            else passed++;
            if (i == 2) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== 32'h0)
                    $display("FAIL stream_first: valid=%b pc=%h, want 1 0", if_valid, if_pc);
                else passed++;
            end
        end
        finish_test("stream", 7);
    endtask

    task automatic test_stall();
        lat = 1; do_reset(); push_seq(32'h0, 5);
        tick(); tick(); tick();
        stall_if = 1'b1; #1;
        checks++;
        if (imem_bus.req !== 1'b0) $display("FAIL stall_noreq0: req=%b, want 0", imem_bus.req); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_bus.req !== 1'b0 || if_pc !== 32'h0 || if_instr !== ~32'h0 || if_valid !== 1'b1)
                $display("FAIL stall_frozen%0d: req=%b pc=%h instr=%h valid=%b, want 0 0 ffffffff 1", i, imem_bus.req, if_pc, if_instr, if_valid);
            else passed++;
        end
        checks++;
        if (dut.hold_buf_q !== ~32'h4) $display("FAIL stall_holdbuf: got %h, want %h", dut.hold_buf_q, ~32'h4); else passed++;
        stall_if = 1'b0;
        tick();
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h8 || if_pc !== 32'h4 || if_valid !== 1'b1)
            $display("FAIL stall_resume: req=%b addr=%h pc=%h valid=%b, want 1 8 4 1", imem_bus.req, imem_bus.addr, if_pc, if_valid);
        else passed++;
        for (int i = 0; i < 5; i++) tick();
        finish_test("stall", 5);
    endtask

    task automatic test_flush_outstanding();
        lat = 3; do_reset(); exp_q.push_back(32'h100);
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b1; redirect_pc = 32'h100;
        tick();
        flush = 1'b0;
        checks++;
        if (if_instr !== 32'h13 || if_valid !== 1'b0 || if_pc !== 32'h100 || imem_bus.req !== 1'b0)
            $display("FAIL flush_bubble: instr=%h valid=%b pc=%h req=%b, want 13 0 100 0", if_instr, if_valid, if_pc, imem_bus.req);
        else passed++;
        tick();
        checks++;
        if (imem_bus.req !== 1'b0) $display("FAIL flush_stale_noreq: req=%b, want 0", imem_bus.req); else passed++;
        tick();
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h100)
            $display("FAIL flush_newaddr: req=%b addr=%h, want 1 100", imem_bus.req, imem_bus.addr);
        else passed++;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== ~32'h100)
            $display("FAIL flush_refill: valid=%b pc=%h instr=%h, want 1 100 %h", if_valid, if_pc, if_instr, ~32'h100);
        else passed++;
        tick();
        finish_test("flush", 1);
    endtask

    task automatic test_flush_rvalid();
        lat = 1; do_reset(); push_seq(32'h200, 2);
        tick(); tick();
        flush = 1'b1; redirect_pc = 32'h203; #1;
        checks++;
        if (imem_bus.req !== 1'b0) $display("FAIL flushrv_noreq: req=%b, want 0", imem_bus.req); else passed++;
        tick();
        flush = 1'b0; #1;
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h200 || if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h200)
            $display("FAIL flushrv_req: req=%b addr=%h valid=%b instr=%h pc=%h, want 1 200 0 13 200", imem_bus.req, imem_bus.addr, if_valid, if_instr, if_pc);
        else passed++;
        tick();
        checks++;
        if (if_valid !== 1'b0) $display("FAIL flushrv_wait: valid=%b, want 0", if_valid); else passed++;
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== ~32'h200)
            $display("FAIL flushrv_refill: valid=%b pc=%h instr=%h, want 1 200 %h", if_valid, if_pc, if_instr, ~32'h200);
        else passed++;
        tick(); tick();
        finish_test("flushrv", 2);
    endtask

    task automatic test_flush_hold();
        lat = 1; do_reset(); push_seq(32'h300, 2);
        tick(); tick(); tick();
        stall_if = 1'b1;
        tick();
        flush = 1'b1; redirect_pc = 32'h300;
        tick();
        flush = 1'b0; #1;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h300 || imem_bus.req !== 1'b0)
            $display("FAIL hold_flush: valid=%b instr=%h pc=%h req=%b, want 0 13 300 0", if_valid, if_instr, if_pc, imem_bus.req);
        else passed++;
        tick();
        stall_if = 1'b0; #1;
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h300)
            $display("FAIL hold_restart: req=%b addr=%h, want 1 300", imem_bus.req, imem_bus.addr);
        else passed++;
        tick(); tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== ~32'h300)
            $display("FAIL hold_refill: valid=%b pc=%h instr=%h, want 1 300 %h", if_valid, if_pc, if_instr, ~32'h300);
        else passed++;
        tick(); tick();
        finish_test("hold", 2);
    endtask

    task automatic test_wrap_reset();
        lat = 1; do_reset();
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        tick();
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_top: req=%b addr=%h, want 1 fffffffc", imem_bus.req, imem_bus.addr);
        else passed++;
        tick();
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0)
            $display("FAIL wrap_zero: req=%b addr=%h, want 1 0", imem_bus.req, imem_bus.addr);
        else passed++;
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || imem_bus.addr !== 32'h4)
            $display("FAIL wrap_ifid: valid=%b pc=%h addr=%h, want 1 fffffffc 4", if_valid, if_pc, imem_bus.addr);
        else passed++;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h13 || if_pc !== 32'h0 || imem_bus.req !== 1'b0)
            $display("FAIL midwait_reset: valid=%b instr=%h pc=%h req=%b, want 0 13 0 0", if_valid, if_instr, if_pc, imem_bus.req);
        else passed++;
        finish_test("wrap", 2);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_outstanding();
        test_flush_rvalid();
        test_flush_hold();
        test_wrap_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
